// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream handshake bundle between the requesters, the arbiter and uart_tx.
// master = requester/uart_tx side, slave = arbiter side.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_data_valid;
  logic              tx_data_ready;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              timeout;

  modport master (
    output req_valid, req_data, req_last, tx_data_ready,
    input  req_ready, tx_data, tx_data_valid, grant, busy, timeout
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_data_ready,
    output req_ready, tx_data, tx_data_valid, grant, busy, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx among NREQ requesters.
// Optional forced release of a stalled owner when UARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int NREQ        = 3,
  parameter int TIMEOUT_CYC = 27000
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, LASTWAIT} state_t;

  state_t          r_state,   w_state_nxt;
  logic [IW-1:0]   r_rr_ptr,  w_rr_ptr_nxt;
  logic [IW-1:0]   r_gidx,    w_gidx_nxt;
  logic [NREQ-1:0] r_grant,   w_grant_nxt;
  logic            r_busy,    w_busy_nxt;
  logic [7:0]      r_tx_data, w_tx_data_nxt;
  logic            r_tx_vld,  w_tx_vld_nxt;
  logic            w_cap;
  logic            w_acc;
  logic            w_own_vld;
  logic [IW-1:0]   w_win;
  logic [IW+2:0]   w_base;

  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                            input logic [IW-1:0]   ptr);
    logic          found;
    logic [IW-1:0] idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (!found && v[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] g);
    next_idx = (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
  endfunction

  assign w_win     = rr_pick(bus.req_valid, r_rr_ptr);
  assign w_own_vld = bus.req_valid[r_gidx];
  assign w_base    = {r_gidx, 3'b000};
  // The buffer is refilled only while empty, so at most one byte is ever in flight.
  assign w_cap     = (r_state == HOLD) && !r_tx_vld && w_own_vld;
  assign w_acc     = r_tx_vld && bus.tx_data_ready;

  // r_grant is one-hot on the owner, so it doubles as the consume strobe mask.
  assign bus.req_ready     = (w_cap && !rst) ? r_grant : '0;
  assign bus.tx_data       = r_tx_data;
  assign bus.tx_data_valid = r_tx_vld;
  assign bus.grant         = r_grant;
  assign bus.busy          = r_busy;

`ifdef UARB_TIMEOUT_EN
  logic [31:0] r_stall, w_stall_nxt;
  logic        r_timeout, w_timeout_nxt;
  logic        w_stall;

  assign w_stall     = (r_state == HOLD) && !r_tx_vld && !w_own_vld;
  assign bus.timeout = r_timeout;
`else
  // No forced release in this build; the owner keeps the grant through any stall.
  assign bus.timeout = 1'b0 && (TIMEOUT_CYC > 0);
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_gidx_nxt    = r_gidx;
    w_grant_nxt   = r_grant;
    w_busy_nxt    = r_busy;
    w_tx_data_nxt = r_tx_data;
    w_tx_vld_nxt  = r_tx_vld;
`ifdef UARB_TIMEOUT_EN
    w_stall_nxt   = r_stall;
    w_timeout_nxt = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (|bus.req_valid) begin
          w_gidx_nxt  = w_win;
          w_grant_nxt = NREQ'(1) << w_win;
          w_busy_nxt  = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (w_acc) w_tx_vld_nxt = 1'b0;
        if (w_cap) begin
          w_tx_data_nxt = bus.req_data[w_base +: 8];
          w_tx_vld_nxt  = 1'b1;
          if (bus.req_last[r_gidx]) w_state_nxt = LASTWAIT;
        end
`ifdef UARB_TIMEOUT_EN
        if (w_cap) begin
          w_stall_nxt = '0;
        end else if (w_stall) begin
          if (r_stall == 32'(TIMEOUT_CYC - 1)) begin
            w_stall_nxt   = '0;
            w_timeout_nxt = 1'b1;
            w_grant_nxt   = '0;
            w_busy_nxt    = 1'b0;
            w_rr_ptr_nxt  = next_idx(r_gidx);
            w_state_nxt   = IDLE;
          end else begin
            w_stall_nxt = r_stall + 32'd1;
          end
        end
`endif
      end
      LASTWAIT: begin
        if (w_acc) begin
          w_tx_vld_nxt = 1'b0;
          w_grant_nxt  = '0;
          w_busy_nxt   = 1'b0;
          w_rr_ptr_nxt = next_idx(r_gidx);
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_gidx    <= '0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_tx_data <= 8'h00;
      r_tx_vld  <= 1'b0;
`ifdef UARB_TIMEOUT_EN
      r_stall   <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_gidx    <= w_gidx_nxt;
      r_grant   <= w_grant_nxt;
      r_busy    <= w_busy_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_tx_vld  <= w_tx_vld_nxt;
`ifdef UARB_TIMEOUT_EN
      r_stall   <= w_stall_nxt;
      r_timeout <= w_timeout_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: three queued requesters and a uart_tx byte monitor.
module tb_uart_tx_arbiter;
  logic clk;
  logic rst;
  int   tests, fails, nonown_err, ovw_err, cyc;
  logic [2:0] en;

  logic [8:0] q0[$], q1[$], q2[$];
  logic [7:0] acc_d[$];
  logic [2:0] acc_g[$];
  int         acc_c[$];

  uart_tx_arbiter_if #(.NREQ(3)) bus ();

  uart_tx_arbiter #(.NREQ(3), .TIMEOUT_CYC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.tx_data_valid && bus.tx_data_ready) begin
      acc_d.push_back(bus.tx_data);
      acc_g.push_back(bus.grant);
      acc_c.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [8:0] f0, f1, f2;
    logic [2:0] has;
    has = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
    f0  = has[0] ? q0[0] : 9'h0;
    f1  = has[1] ? q1[0] : 9'h0;
    f2  = has[2] ? q2[0] : 9'h0;
    bus.req_valid = has & en;
    bus.req_data  = {f2[7:0], f1[7:0], f0[7:0]};
    bus.req_last  = {f2[8], f1[8], f0[8]};
    #1;
  endtask

  task automatic step();
    logic [2:0] c;
    @(negedge clk);
    c = bus.req_ready;
    if ((c & ~bus.grant) != 3'b000) nonown_err++;
    if (c != 3'b000 && bus.tx_data_valid) ovw_err++;
    @(posedge clk);
    #1;
    cyc++;
    if (c[0]) void'(q0.pop_front());
    if (c[1]) void'(q1.pop_front());
    if (c[2]) void'(q2.pop_front());
    drive();
  endtask

  task automatic run_idle(input string tag, input int max);
    int n;
    n = 0;
    while (!(((q0.size() == 0) || !en[0]) && ((q1.size() == 0) || !en[1]) &&
             ((q2.size() == 0) || !en[2]) && !bus.busy && !bus.tx_data_valid) && n < max) begin
      step();
      n++;
    end
    chk(tag, n < max, 1);
  endtask

  initial begin
    int  g1;
    int  stall;
    logic stable, rdy_seen, held, to_seen;
    tests = 0; fails = 0; nonown_err = 0; ovw_err = 0; cyc = 0;
    en = 3'b111;
    rst = 1'b1;
    bus.tx_data_ready = 1'b0;
    drive();
    step();
    step();
    chk("rst_grant",   bus.grant, 0);
    chk("rst_busy",    bus.busy, 0);
    chk("rst_vld",     bus.tx_data_valid, 0);
    chk("rst_data",    bus.tx_data, 8'h00);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_ready",   bus.req_ready, 0);
    rst = 1'b0;

    // T1: "AB" from requester 0, uart_tx ready one cycle after the first byte appears
    q0.push_back({1'b0, 8'h41});
    q0.push_back({1'b1, 8'h42});
    drive();
    step();
    chk("t1_grant_c1", bus.grant, 3'b001);
    chk("t1_busy",     bus.busy, 1);
    chk("t1_ready_c1", bus.req_ready, 3'b001);
    step();
    chk("t1_data_A",   bus.tx_data, 8'h41);
    chk("t1_vld_A",    bus.tx_data_valid, 1);
    chk("t1_no_ready", bus.req_ready, 0);
    bus.tx_data_ready = 1'b1;
    step();
    chk("t1_vld_clr",  bus.tx_data_valid, 0);
    step();
    chk("t1_data_B",   bus.tx_data, 8'h42);
    chk("t1_vld_B",    bus.tx_data_valid, 1);
    step();
    chk("t1_release",  bus.grant, 0);
    chk("t1_idle",     bus.busy, 0);
    chk("t1_acc_n",    acc_d.size(), 2);
    chk("t1_acc0",     acc_d[0], 8'h41);
    chk("t1_acc1",     acc_d[1], 8'h42);

    // rr_ptr is now 1: requester 1 wins over requester 0
    acc_d.delete(); acc_g.delete(); acc_c.delete();
    q0.push_back({1'b1, 8'h43});
    q1.push_back({1'b1, 8'h5A});
    drive();
    step();
    chk("t1_rr_grant", bus.grant, 3'b010);
    run_idle("t1_rr_drain", 50);
    chk("t1_rr_d0", acc_d[0], 8'h5A);
    chk("t1_rr_g0", acc_g[0], 3'b010);
    chk("t1_rr_d1", acc_d[1], 8'h43);
    chk("t1_rr_g1", acc_g[1], 3'b001);

    // T2: three simultaneous single-byte packets after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    acc_d.delete(); acc_g.delete(); acc_c.delete();
    q0.push_back({1'b1, 8'h30});
    q1.push_back({1'b1, 8'h31});
    q2.push_back({1'b1, 8'h32});
    drive();
    run_idle("t2_drain", 80);
    chk("t2_acc_n", acc_d.size(), 3);
    chk("t2_d0", acc_d[0], 8'h30);
    chk("t2_g0", acc_g[0], 3'b001);
    chk("t2_d1", acc_d[1], 8'h31);
    chk("t2_g1", acc_g[1], 3'b010);
    chk("t2_d2", acc_d[2], 8'h32);
    chk("t2_g2", acc_g[2], 3'b100);
    q0.push_back({1'b1, 8'h77});
    q2.push_back({1'b1, 8'h79});
    drive();
    step();
    chk("t2_wrap_grant", bus.grant, 3'b001);
    run_idle("t2_wrap_drain", 50);

    // T3: owner 0 sends 3 bytes; requester 1 arrives after byte 1 and must wait
    acc_d.delete(); acc_g.delete(); acc_c.delete();
    q0.push_back({1'b0, 8'h61});
    q0.push_back({1'b0, 8'h62});
    q0.push_back({1'b1, 8'h63});
    drive();
    step();
    step();
    q1.push_back({1'b1, 8'h71});
    drive();
    g1 = -1;
    for (int n = 0; n < 60 && g1 < 0; n++) begin
      step();
      if (bus.grant == 3'b010) g1 = cyc;
    end
    chk("t3_grant1_seen", g1 >= 0, 1);
    chk("t3_d0", acc_d[0], 8'h61);
    chk("t3_d1", acc_d[1], 8'h62);
    chk("t3_g1", acc_g[1], 3'b001);
    chk("t3_d2", acc_d[2], 8'h63);
    chk("t3_g2", acc_g[2], 3'b001);
    chk("t3_rel_to_grant", g1 - acc_c[2], 2);
    run_idle("t3_drain", 50);
    chk("t3_d3", acc_d[3], 8'h71);
    chk("t3_g3", acc_g[3], 3'b010);

    // T4: uart_tx stalls for 100 cycles with a byte pending
    acc_d.delete(); acc_g.delete(); acc_c.delete();
    bus.tx_data_ready = 1'b0;
    q2.push_back({1'b0, 8'h58});
    q2.push_back({1'b1, 8'h59});
    drive();
    step();
    step();
    chk("t4_vld",  bus.tx_data_valid, 1);
    chk("t4_data", bus.tx_data, 8'h58);
    stable = 1'b1;
    rdy_seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (bus.tx_data !== 8'h58 || bus.tx_data_valid !== 1'b1) stable = 1'b0;
      if (bus.req_ready !== 3'b000) rdy_seen = 1'b1;
    end
    chk("t4_stable",   stable, 1);
    chk("t4_no_ready", rdy_seen, 0);
    bus.tx_data_ready = 1'b1;
    drive();
    run_idle("t4_drain", 50);
    chk("t4_acc_n", acc_d.size(), 2);
    chk("t4_d1",    acc_d[1], 8'h59);
    chk("t4_g1",    acc_g[1], 3'b100);

    // T5: reset in the middle of a requester-2 packet
    acc_d.delete(); acc_g.delete(); acc_c.delete();
    q2.push_back({1'b0, 8'hA1});
    q2.push_back({1'b0, 8'hA2});
    q2.push_back({1'b1, 8'hA3});
    bus.tx_data_ready = 1'b0;
    drive();
    step();
    step();
    chk("t5_pre_grant", bus.grant, 3'b100);
    chk("t5_pre_vld",   bus.tx_data_valid, 1);
    rst = 1'b1;
    drive();
    step();
    chk("t5_grant",   bus.grant, 0);
    chk("t5_busy",    bus.busy, 0);
    chk("t5_vld",     bus.tx_data_valid, 0);
    chk("t5_data",    bus.tx_data, 8'h00);
    chk("t5_timeout", bus.timeout, 0);
    chk("t5_ready",   bus.req_ready, 0);
    rst = 1'b0;
    q2.delete();
    q1.push_back({1'b1, 8'hB1});
    q2.push_back({1'b1, 8'hB2});
    drive();
    step();
    chk("t5_grant_after", bus.grant, 3'b010);
    bus.tx_data_ready = 1'b1;
    drive();
    run_idle("t5_drain", 50);
    chk("t5_acc_n", acc_d.size(), 2);
    chk("t5_d0",    acc_d[0], 8'hB1);

    // T6: owner 0 drops req_valid after its first byte
    acc_d.delete(); acc_g.delete(); acc_c.delete();
    q0.push_back({1'b0, 8'hC1});
    q0.push_back({1'b1, 8'hC2});
    q1.push_back({1'b1, 8'hD1});
    drive();
    step();
    chk("t6_grant", bus.grant, 3'b001);
    step();
    en[0] = 1'b0;
    drive();
`ifdef UARB_TIMEOUT_EN
    stall = 0;
    to_seen = 1'b0;
    for (int n = 0; n < 40 && !to_seen; n++) begin
      step();
      if (bus.timeout === 1'b1) to_seen = 1'b1;
      else if (bus.grant == 3'b001 && !bus.tx_data_valid) stall++;
    end
    chk("t6_timeout_seen", to_seen, 1);
    chk("t6_stall_cycles", stall, 16);
    chk("t6_release",      bus.grant, 0);
    chk("t6_release_busy", bus.busy, 0);
    step();
    chk("t6_pulse_end",    bus.timeout, 0);
    chk("t6_next_grant",   bus.grant, 3'b010);
    run_idle("t6_drain", 50);
    chk("t6_acc_n", acc_d.size(), 2);
    chk("t6_d1",    acc_d[1], 8'hD1);
    chk("t6_g1",    acc_g[1], 3'b010);
`else
    held = 1'b1;
    for (int n = 0; n < 40; n++) begin
      step();
      if (bus.grant !== 3'b001 || bus.timeout !== 1'b0) held = 1'b0;
    end
    chk("t6_grant_held", held, 1);
    chk("t6_acc_n", acc_d.size(), 1);
`endif
    rst = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    en = 3'b111;
    drive();
    step();
    rst = 1'b0;

    chk("nonowner_ready",    nonown_err, 0);
    chk("ready_while_valid", ovw_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
